// File: rtl/vram_arbiter_pkg.sv
// Shared constants and types for the VRAM time-slot arbiter.
// Provides bus widths, slot encodings, the CPU FSM state type and the ink-table base.
package vram_arb_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;

  localparam logic SLOT_VID = 1'b0;
  localparam logic SLOT_CPU = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DONE = 2'd2
  } cpu_state_e;

  localparam logic [ADDR_W-1:0] INK_BASE = 15'h7D00;

endpackage

// File: rtl/vram_arbiter_if.sv
// CPU-side request/acknowledge bus into the VRAM arbiter.
// The master modport is the CPU bus bridge; the slave modport is the arbiter.
interface vram_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata
  );

endinterface

// File: rtl/vram_arbiter.sv
// Time-slot arbiter for the single-port VRAM: even cycles feed video scan-out, odd cycles serve the CPU.
// Optional VRAM_ARB_BLANK_BOOST_EN hands idle video slots to the CPU while vid_blank is high.
module vram_arbiter #(
  parameter int ADDR_W = vram_arb_pkg::ADDR_W,
  parameter int DATA_W = vram_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic              vid_blank,
  output logic [DATA_W-1:0] vid_data,
  vram_arbiter_if.slave     cpu,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  import vram_arb_pkg::*;

  logic              phase_q;
  cpu_state_e        state_q, state_d;
  logic              vidRead_q;
  logic              isRead_q;
  logic [DATA_W-1:0] vidData_q;
  logic [DATA_W-1:0] cpuRdata_q;

  logic boost;
  logic cpuIssue;
  logic vidSlotUsed;

`ifdef VRAM_ARB_BLANK_BOOST_EN
  assign boost = (phase_q == SLOT_VID) && vid_blank && (state_q == IDLE) && cpu.cpu_req;
`else
  logic unusedBlank;
  assign boost       = 1'b0;
  assign unusedBlank = vid_blank;
`endif

  assign vidSlotUsed = (phase_q == SLOT_VID) && !boost;
  assign cpuIssue    = (state_q == IDLE) && cpu.cpu_req && ((phase_q == SLOT_CPU) || boost);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpuIssue) state_d = PEND;
      PEND:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data arrives one cycle after the address, so both capture paths look at the previous slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= SLOT_VID;
      state_q    <= IDLE;
      vidRead_q  <= 1'b0;
      isRead_q   <= 1'b0;
      vidData_q  <= '0;
      cpuRdata_q <= '0;
    end else begin
      phase_q   <= ~phase_q;
      state_q   <= state_d;
      vidRead_q <= vidSlotUsed;
      if (vidRead_q) vidData_q <= ram_rdata;
      if (cpuIssue) isRead_q <= !cpu.cpu_we;
      if ((state_q == PEND) && isRead_q) cpuRdata_q <= ram_rdata;
    end
  end

  // RAM controls are forced low while reset is held so no stray write reaches the macro.
  assign ram_addr  = !rst_n ? '0 : (vidSlotUsed ? vid_addr : cpu.cpu_addr);
  assign ram_we    = rst_n && cpuIssue && cpu.cpu_we;
  assign ram_wdata = !rst_n ? '0 : cpu.cpu_wdata;

  assign vid_data      = vidData_q;
  assign cpu.cpu_ack   = (state_q == DONE);
  assign cpu.cpu_rdata = cpuRdata_q;

endmodule
